// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D line-memory port arbiter: FSM states, port ids and
// the watchdog counter width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RECOVER} arb_state_t;

  typedef enum logic {PORT_I, PORT_D} port_t;

  // Watchdog counter width: enough bits for the limit, kept within 8..16.
  function automatic int timeout_cnt_w(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-side, D-side and downstream line-memory signals around the
// arbiter; master is the arbiter's view, slave the surrounding environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256
);
  logic                  strobe_imem;
  logic [ADDR_WIDTH-1:0] addr_imem_i;
  logic [DATA_WIDTH-1:0] rdata_imem_o;
  logic                  done_imem_o;

  logic                  strobe_dmem;
  logic [ADDR_WIDTH-1:0] addr_dmem_i;
  logic [DATA_WIDTH-1:0] wdata_dmem_i;
  logic                  rw_dmem_i;
  logic [DATA_WIDTH-1:0] rdata_dmem_o;
  logic                  done_dmem_o;

  logic                  mem_strobe_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_rw_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_done_i;

  logic                  busy_o;
  logic                  err_o;

  modport master (
    input  strobe_imem, addr_imem_i,
    input  strobe_dmem, addr_dmem_i, wdata_dmem_i, rw_dmem_i,
    input  mem_rdata_i, mem_done_i,
    output rdata_imem_o, done_imem_o, rdata_dmem_o, done_dmem_o,
    output mem_strobe_o, mem_addr_o, mem_wdata_o, mem_rw_o,
    output busy_o, err_o
  );

  modport slave (
    output strobe_imem, addr_imem_i,
    output strobe_dmem, addr_dmem_i, wdata_dmem_i, rw_dmem_i,
    output mem_rdata_i, mem_done_i,
    input  rdata_imem_o, done_imem_o, rdata_dmem_o, done_dmem_o,
    input  mem_strobe_o, mem_addr_o, mem_wdata_o, mem_rw_o,
    input  busy_o, err_o
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: on a tie the port that was not granted last wins.
// Purely combinational; the last-grant state lives in the parent.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  port_t      last_grant,
  output logic       grant_valid,
  output port_t      grant_id
);

  logic [1:0] eligible;

  assign eligible = req & ~mask;

  always_comb begin
    grant_valid = |eligible;
    grant_id    = PORT_I;
    if (eligible == 2'b11)
      grant_id = (last_grant == PORT_I) ? PORT_D : PORT_I;
    else if (eligible[1])
      grant_id = PORT_D;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises I-side reads and D-side reads/writes onto one line-wide memory port.
// Optional WAIT watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.master bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES out of range 1..65536");
  end

  arb_state_t            state_q, state_d;
  port_t                 winner_q, last_grant_q, grant_id;
  logic                  grant_valid;
  logic                  mask_q;
  logic [1:0]            mask;
  logic                  timeout_hit;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rw_q;
  logic [DATA_WIDTH-1:0] rdata_i_q, rdata_d_q;

  // The port served last sits out the first IDLE cycle, so a strobe still
  // high right after its done pulse is not mistaken for a new request.
  assign mask = mask_q ? ((last_grant_q == PORT_I) ? 2'b01 : 2'b10) : 2'b00;

  rr_arbiter2 u_rr (
    .req        ({bus.strobe_dmem, bus.strobe_imem}),
    .mask       (mask),
    .last_grant (last_grant_q),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (state_q != WAIT)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.mem_done_i || timeout_hit) state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture in IDLE; later requester changes are ignored until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner_q     <= PORT_I;
      last_grant_q <= PORT_D;
      mask_q       <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rw_q         <= 1'b0;
      rdata_i_q    <= '0;
      rdata_d_q    <= '0;
    end else begin
      mask_q <= (state_q == RECOVER);
      if (state_q == IDLE && grant_valid) begin
        winner_q <= grant_id;
        if (grant_id == PORT_I) begin
          addr_q  <= bus.addr_imem_i;
          wdata_q <= '0;
          rw_q    <= 1'b0;
        end else begin
          addr_q  <= bus.addr_dmem_i;
          wdata_q <= bus.wdata_dmem_i;
          rw_q    <= bus.rw_dmem_i;
        end
      end
      if (state_q == WAIT) begin
        err_q <= timeout_hit && !bus.mem_done_i;
        if (bus.mem_done_i && !rw_q) begin
          if (winner_q == PORT_I)
            rdata_i_q <= bus.mem_rdata_i;
          else
            rdata_d_q <= bus.mem_rdata_i;
        end
      end
      if (state_q == RECOVER)
        last_grant_q <= winner_q;
    end
  end

  assign bus.mem_strobe_o = (state_q == ISSUE);
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = wdata_q;
  assign bus.mem_rw_o     = rw_q;
  assign bus.rdata_imem_o = rdata_i_q;
  assign bus.rdata_dmem_o = rdata_d_q;
  assign bus.done_imem_o  = (state_q == RECOVER) && (winner_q == PORT_I);
  assign bus.done_dmem_o  = (state_q == RECOVER) && (winner_q == PORT_D);
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.err_o        = (state_q == RECOVER) && err_q;

endmodule
